control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//  Multicycle main controller for the RV32I datapath. Sequences fetch, decode, execute, memory and writeback
//  by driving every datapath enable and mux select from a Moore FSM plus the ALU-op decoder.
//  Decodes the latched instruction (InstrPast_i). Branch resolution comes from the datapath's branch unit (Branch_i).
// PARAMETERS
//  HALT_ON_ILLEGAL  1  1: unknown opcode -> HALT (sticky until reset); 0: treat as NOP, return to FETCH
// PORTS
//  clk_i            in   1         clock, all state updates on rising edge
//  rst_i            in   1         synchronous reset, active-high
//  InstrPast_i      in   XLEN      instruction register contents
//  Branch_i         in   1         branch-taken flag, valid when B_EN_o=1
//  PCWrite_o        out  1         PC load enable
//  MemWrite_o       out  1         data memory write enable
//  IRWrite_o        out  1         instruction/old-PC register load enable
//  RegWrite_o       out  1         register file write enable
//  ImmSrc_o         out  3         000 I, 001 S, 010 B, 011 U, 100 J
//  ALUSrcA_o        out  2         00 PC, 01 OldPC, 10 rs1, 11 zero
//  ALUSrcB_o        out  2         00 rs2, 01 imm, 10 const 4, 11 zero
//  ALUControl_o     out  alu_op_e  ALU operation (riscv_pkg)
//  ResultSrc_o      out  2         00 ALUOut reg, 01 ALU comb, 10 EXT, 11 LSU
//  B_EN_o           out  1         branch unit enable
//  retire_o         out  1         1-cycle pulse in final state of each instruction
//  halted_o         out  1         1 while in HALT
// BEHAVIOUR
//  Reset: rst_i=1 at an edge -> state FETCH. While rst_i=1, all enables/pulses (PCWrite, MemWrite, IRWrite,
//   RegWrite, B_EN, retire, halted) forced 0; selects 0, ALUControl=ADD. Reset wins mid-instruction and from HALT.
//  Outputs are combinational from state (+InstrPast_i fields, Branch_i). Unlisted signals = 0 / ADD.
//  FETCH    : IRWrite=1, SrcA=00, SrcB=10, ADD, ResultSrc=01, PCWrite=1 (PC<=PC+4) -> DECODE
//  DECODE   : SrcA=01, SrcB=01, ImmSrc=B, ADD (ALUOut<=OldPC+immB). By opcode: load/store->MEMADR,
//             R->EXEC_R, OP-IMM->EXEC_I, branch->BRANCH, JAL->JAL_JUMP, JALR->JALR_JUMP, LUI->LUI,
//             AUIPC->AUIPC, FENCE/SYSTEM->FETCH (retire=1, NOP), else HALT or FETCH per HALT_ON_ILLEGAL
//  MEMADR   : SrcA=10, SrcB=01, ImmSrc=I(load)/S(store), ADD -> MEMREAD or MEMWRITE
//  MEMREAD  : ResultSrc=00 (address) -> MEMWB
//  MEMWB    : ResultSrc=11, RegWrite=1, retire -> FETCH
//  MEMWRITE : ResultSrc=00, MemWrite=1, retire -> FETCH
//  EXEC_R   : SrcA=10, SrcB=00, op from funct3/funct7[5] -> ALUWB
//  EXEC_I   : SrcA=10, SrcB=01, ImmSrc=I, op from funct3 (funct7[5] only for SRAI) -> ALUWB
//  ALUWB    : ResultSrc=00, RegWrite=1, retire -> FETCH
//  BRANCH   : B_EN=1, ResultSrc=00, PCWrite=Branch_i, retire -> FETCH
//  JAL_JUMP : SrcA=01, SrcB=01, ImmSrc=J, ADD, ResultSrc=01, PCWrite=1 -> LINK
//  JALR_JUMP: SrcA=10, SrcB=01, ImmSrc=I, ADD, ResultSrc=01, PCWrite=1 -> LINK (bit0 not cleared)
//  LINK     : SrcA=01, SrcB=10, ADD, ResultSrc=01, RegWrite=1 (rd<=OldPC+4), retire -> FETCH
//             jump precedes link so JALR with rd==rs1 uses the old rs1
//  LUI      : ImmSrc=U, ResultSrc=10, RegWrite=1, retire -> FETCH
//  AUIPC    : SrcA=01, SrcB=01, ImmSrc=U, ADD, ResultSrc=01, RegWrite=1, retire -> FETCH
//  HALT     : halted=1, all enables 0, self-loop until rst_i
//  Latency (cycles incl. FETCH): load 5; R/I-ALU, store, JAL, JALR 4; branch, LUI, AUIPC 3; NOP 2.
//  ALU decode: funct3 000 ADD/SUB (SUB only R with f7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR,
//   101 SRL/SRA (f7[5]), 110 OR, 111 AND. Writes to x0 are the register file's concern; controller writes normally.
// TESTING
//  reset 3 cycles then release -> first cycle FETCH: IRWrite=PCWrite=1, SrcB=10; PC 0->4 next edge
//  ADD x3,x1,x2 (x1=5,x2=7) -> 4 cycles, RegWrite in cycle 4 only, x3=12, retire pulse once
//  LW x4,8(x0) with mem[8]=0xDEADBEEF -> 5 cycles, MEMWB ResultSrc=11, x4=0xDEADBEEF
//  BEQ x1,x1,+16 at PC=0x20 -> PC=0x30 after 3 cycles; BNE x1,x1 -> PCWrite=0, PC=0x24
//  JALR x1,4(x1) with x1=0x100, at PC=0x40 -> PC=0x104, x1=0x44 (jump uses old x1)
//  opcode 0x7F, HALT_ON_ILLEGAL=1 -> halted_o=1 and stays; rst_i pulse mid-HALT -> FETCH, halted_o=0

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width and the ALU operation encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

endpackage

// File: rtl/control_fsm.sv
// Multicycle RV32I main controller: Moore FSM plus ALU-op decoder driving all datapath enables/selects.
// Latency: load 5, R/I-ALU/store/JAL/JALR 4, branch/LUI/AUIPC 3, FENCE/SYSTEM 2 cycles including FETCH.
// Backpressure: none; the datapath is assumed to complete every step in one cycle.
module control_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [riscv_pkg::XLEN-1:0]   InstrPast_i,
    input  logic                         Branch_i,
    output logic                         PCWrite_o,
    output logic                         MemWrite_o,
    output logic                         IRWrite_o,
    output logic                         RegWrite_o,
    output logic [2:0]                   ImmSrc_o,
    output logic [1:0]                   ALUSrcA_o,
    output logic [1:0]                   ALUSrcB_o,
    output riscv_pkg::alu_op_e           ALUControl_o,
    output logic [1:0]                   ResultSrc_o,
    output logic                         B_EN_o,
    output logic                         retire_o,
    output logic                         halted_o
);
    import riscv_pkg::*;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL_JUMP, S_JALR_JUMP,
        S_LINK, S_LUI, S_AUIPC, S_HALT
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    state_e     state_q, state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_instr;

    assign opcode       = InstrPast_i[6:0];
    assign funct3       = InstrPast_i[14:12];
    assign funct7_b5    = InstrPast_i[30];
    // Register indices and immediates are consumed by the datapath, not here.
    assign unused_instr = ^{InstrPast_i[31], InstrPast_i[29:15], InstrPast_i[11:7]};

    // funct7[5] selects SUB only for register-register ops; for shifts it selects arithmetic.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // State register; reset is synchronous and wins from any state, including HALT.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next state and Moore outputs; reset forces every enable low and selects to zero.
    always_comb begin
        state_d      = state_q;
        PCWrite_o    = 1'b0;
        MemWrite_o   = 1'b0;
        IRWrite_o    = 1'b0;
        RegWrite_o   = 1'b0;
        ImmSrc_o     = IMM_I;
        ALUSrcA_o    = 2'b00;
        ALUSrcB_o    = 2'b00;
        ALUControl_o = ALU_ADD;
        ResultSrc_o  = 2'b00;
        B_EN_o       = 1'b0;
        retire_o     = 1'b0;
        halted_o     = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite_o   = 1'b1;
                ALUSrcB_o   = 2'b10;
                ResultSrc_o = 2'b01;
                PCWrite_o   = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b01;
                ImmSrc_o  = IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE:     state_d = S_MEMADR;
                    OP_R:                  state_d = S_EXEC_R;
                    OP_IMM:                state_d = S_EXEC_I;
                    OP_BRANCH:             state_d = S_BRANCH;
                    OP_JAL:                state_d = S_JAL_JUMP;
                    OP_JALR:               state_d = S_JALR_JUMP;
                    OP_LUI:                state_d = S_LUI;
                    OP_AUIPC:              state_d = S_AUIPC;
                    OP_FENCE, OP_SYSTEM: begin
                        retire_o = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        retire_o = !HALT_ON_ILLEGAL;
                        state_d  = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA_o = 2'b10;
                ALUSrcB_o = 2'b01;
                ImmSrc_o  = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ResultSrc_o = 2'b00;
                state_d     = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc_o = 2'b11;
                RegWrite_o  = 1'b1;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                MemWrite_o = 1'b1;
                retire_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA_o    = 2'b10;
                ALUSrcB_o    = 2'b00;
                ALUControl_o = alu_decode(funct3, funct7_b5, 1'b1);
                state_d      = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA_o    = 2'b10;
                ALUSrcB_o    = 2'b01;
                ImmSrc_o     = IMM_I;
                ALUControl_o = alu_decode(funct3, funct7_b5, 1'b0);
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite_o = 1'b1;
                retire_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                B_EN_o    = 1'b1;
                PCWrite_o = Branch_i;
                retire_o  = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL_JUMP: begin
                ALUSrcA_o   = 2'b01;
                ALUSrcB_o   = 2'b01;
                ImmSrc_o    = IMM_J;
                ResultSrc_o = 2'b01;
                PCWrite_o   = 1'b1;
                state_d     = S_LINK;
            end
            S_JALR_JUMP: begin
                // Jump before link so rd==rs1 still sees the old rs1.
                ALUSrcA_o   = 2'b10;
                ALUSrcB_o   = 2'b01;
                ImmSrc_o    = IMM_I;
                ResultSrc_o = 2'b01;
                PCWrite_o   = 1'b1;
                state_d     = S_LINK;
            end
            S_LINK: begin
                ALUSrcA_o   = 2'b01;
                ALUSrcB_o   = 2'b10;
                ResultSrc_o = 2'b01;
                RegWrite_o  = 1'b1;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_LUI: begin
                ImmSrc_o    = IMM_U;
                ResultSrc_o = 2'b10;
                RegWrite_o  = 1'b1;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_AUIPC: begin
                ALUSrcA_o   = 2'b01;
                ALUSrcB_o   = 2'b01;
                ImmSrc_o    = IMM_U;
                ResultSrc_o = 2'b01;
                RegWrite_o  = 1'b1;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            default: begin
                halted_o = 1'b1;
                state_d  = S_HALT;
            end
        endcase

        if (rst_i) begin
            PCWrite_o    = 1'b0;
            MemWrite_o   = 1'b0;
            IRWrite_o    = 1'b0;
            RegWrite_o   = 1'b0;
            ImmSrc_o     = 3'b000;
            ALUSrcA_o    = 2'b00;
            ALUSrcB_o    = 2'b00;
            ALUControl_o = ALU_ADD;
            ResultSrc_o  = 2'b00;
            B_EN_o       = 1'b0;
            retire_o     = 1'b0;
            halted_o     = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] InstrPast_i;
    logic        Branch_i;
    logic        PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o;
    logic [2:0]  ImmSrc_o;
    logic [1:0]  ALUSrcA_o, ALUSrcB_o, ResultSrc_o;
    alu_op_e     ALUControl_o;
    logic        B_EN_o, retire_o, halted_o;

    control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .InstrPast_i(InstrPast_i), .Branch_i(Branch_i),
        .PCWrite_o(PCWrite_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
        .RegWrite_o(RegWrite_o), .ImmSrc_o(ImmSrc_o), .ALUSrcA_o(ALUSrcA_o),
        .ALUSrcB_o(ALUSrcB_o), .ALUControl_o(ALUControl_o), .ResultSrc_o(ResultSrc_o),
        .B_EN_o(B_EN_o), .retire_o(retire_o), .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        br;
        int          lat;     // cycles from FETCH to retire, inclusive
        int          rw_n;    // RegWrite cycles
        int          pcw_n;   // PCWrite cycles (FETCH included)
        int          mw_n;    // MemWrite cycles
        int          ben_n;   // B_EN cycles
        logic [3:0]  alu3;    // ALUControl in third cycle
        logic [2:0]  imm3;    // ImmSrc in third cycle
        logic [1:0]  rs_last; // ResultSrc in the retiring cycle
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] i, input logic b, input int lat,
                                input int rw, input int pcw, input int mw, input int ben,
                                input alu_op_e a3, input logic [2:0] im3, input logic [1:0] rs);
        vec_t v;
        v.name = n; v.instr = i; v.br = b; v.lat = lat; v.rw_n = rw; v.pcw_n = pcw;
        v.mw_n = mw; v.ben_n = ben; v.alu3 = a3; v.imm3 = im3; v.rs_last = rs;
        return v;
    endfunction

    function automatic logic [31:0] all_outs();
        return {12'd0, PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, B_EN_o, retire_o, halted_o,
                ImmSrc_o, ALUSrcA_o, ALUSrcB_o, ResultSrc_o, ALUControl_o};
    endfunction

    // Drive one instruction starting in a FETCH cycle; expected record goes into the scoreboard,
    // observed behaviour is collected until retire and compared against the popped record.
    task automatic run_vec(input vec_t v);
        int cyc = 0;
        int rw_n = 0, pcw_n = 0, mw_n = 0, ben_n = 0;
        logic [3:0] alu3 = 4'(ALU_ADD);
        logic [2:0] imm3 = 3'b000;
        logic [1:0] rs_last = 2'b00;
        bit done = 0;
        vec_t e;
        InstrPast_i = v.instr;
        Branch_i    = v.br;
        sb.push_back(v);
        while (!done && cyc < 12) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 1)
                chk({v.name, "_fetch"}, {IRWrite_o, PCWrite_o, ALUSrcA_o, ALUSrcB_o, ResultSrc_o},
                    {1'b1, 1'b1, 2'b00, 2'b10, 2'b01});
            if (cyc == 2)
                chk({v.name, "_decode"}, {IRWrite_o, ALUSrcA_o, ALUSrcB_o, ImmSrc_o},
                    {1'b0, 2'b01, 2'b01, 3'b010});
            if (cyc == 3) begin
                alu3 = ALUControl_o;
                imm3 = ImmSrc_o;
            end
            rw_n  += int'(RegWrite_o);
            pcw_n += int'(PCWrite_o);
            mw_n  += int'(MemWrite_o);
            ben_n += int'(B_EN_o);
            if (retire_o) begin
                done    = 1;
                rs_last = ResultSrc_o;
            end
        end
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        chk({e.name, "_latency"}, done ? cyc : 99, e.lat);
        chk({e.name, "_regwrite_n"}, rw_n, e.rw_n);
        chk({e.name, "_pcwrite_n"}, pcw_n, e.pcw_n);
        chk({e.name, "_memwrite_n"}, mw_n, e.mw_n);
        chk({e.name, "_ben_n"}, ben_n, e.ben_n);
        chk({e.name, "_alu_c3"}, alu3, e.alu3);
        chk({e.name, "_imm_c3"}, imm3, e.imm3);
        chk({e.name, "_rsrc_last"}, rs_last, e.rs_last);
    endtask

    initial begin
        vecs.push_back(mk("add",   32'h002081B3, 0, 4, 1, 1, 0, 0, ALU_ADD,  3'b000, 2'b00));
        vecs.push_back(mk("sub",   32'h402081B3, 0, 4, 1, 1, 0, 0, ALU_SUB,  3'b000, 2'b00));
        vecs.push_back(mk("sra",   32'h4020D1B3, 0, 4, 1, 1, 0, 0, ALU_SRA,  3'b000, 2'b00));
        vecs.push_back(mk("sltu",  32'h0020B1B3, 0, 4, 1, 1, 0, 0, ALU_SLTU, 3'b000, 2'b00));
        vecs.push_back(mk("addi",  32'h40008193, 0, 4, 1, 1, 0, 0, ALU_ADD,  3'b000, 2'b00));
        vecs.push_back(mk("srai",  32'h4030D193, 0, 4, 1, 1, 0, 0, ALU_SRA,  3'b000, 2'b00));
        vecs.push_back(mk("slli",  32'h00109193, 0, 4, 1, 1, 0, 0, ALU_SLL,  3'b000, 2'b00));
        vecs.push_back(mk("xori",  32'h0010C193, 0, 4, 1, 1, 0, 0, ALU_XOR,  3'b000, 2'b00));
        vecs.push_back(mk("lw",    32'h00802203, 0, 5, 1, 1, 0, 0, ALU_ADD,  3'b000, 2'b11));
        vecs.push_back(mk("sw",    32'h00202423, 0, 4, 0, 1, 1, 0, ALU_ADD,  3'b001, 2'b00));
        vecs.push_back(mk("beq_t", 32'h00108863, 1, 3, 0, 2, 0, 1, ALU_ADD,  3'b000, 2'b00));
        vecs.push_back(mk("bne_n", 32'h00109863, 0, 3, 0, 1, 0, 1, ALU_ADD,  3'b000, 2'b00));
        vecs.push_back(mk("jal",   32'h008000EF, 0, 4, 1, 2, 0, 0, ALU_ADD,  3'b100, 2'b01));
        vecs.push_back(mk("jalr",  32'h004080E7, 0, 4, 1, 2, 0, 0, ALU_ADD,  3'b000, 2'b01));
        vecs.push_back(mk("lui",   32'h123452B7, 0, 3, 1, 1, 0, 0, ALU_ADD,  3'b011, 2'b10));
        vecs.push_back(mk("auipc", 32'h12345297, 0, 3, 1, 1, 0, 0, ALU_ADD,  3'b011, 2'b01));
        vecs.push_back(mk("fence", 32'h0000000F, 0, 2, 0, 1, 0, 0, ALU_ADD,  3'b000, 2'b00));
        vecs.push_back(mk("ecall", 32'h00000073, 0, 2, 0, 1, 0, 0, ALU_ADD,  3'b000, 2'b00));

        // Reset held for three cycles: everything low, ALU op ADD.
        rst_i       = 1'b1;
        InstrPast_i = 32'h002081B3;
        Branch_i    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("reset_outputs", all_outs(), 32'd0);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Illegal opcode: halts and stays halted with no enables.
        InstrPast_i = 32'h0000007F;
        Branch_i    = 1'b0;
        @(negedge clk_i);
        chk("illegal_fetch", IRWrite_o, 1'b1);
        @(negedge clk_i);
        chk("illegal_decode_retire", retire_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("halt_state", {halted_o, PCWrite_o, IRWrite_o, RegWrite_o, MemWrite_o, retire_o},
                6'b100000);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("halt_reset_outputs", all_outs(), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        run_vec(vecs[0]);
        chk("halt_cleared", halted_o, 1'b0);

        // Reset in the middle of a load: back to FETCH, then a full load runs normally.
        InstrPast_i = 32'h00802203;
        repeat (3) @(negedge clk_i);
        chk("midload_memadr_imm", {ALUSrcA_o, ALUSrcB_o, ImmSrc_o}, {2'b10, 2'b01, 3'b000});
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midload_reset_outputs", all_outs(), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        run_vec(vecs[8]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
